muldiv_issue_stage: RTL and testbench
=====================================

Name: muldiv_issue_stage

Overview:
Sequential issue/result stage that wraps the team's 16-bit combinational multiplier and divider (Multiply_16, Divide_16).
- Upstream: accepts an operand pair and opcode over a valid/ready handshake and holds the operands in registers that drive both units.
- Settling: waits a programmable number of cycles so the long ripple paths are timed as multicycle paths.
- Downstream: captures the selected result into an output register and presents it on a valid/ready handshake.
- Divide-by-zero is detected here, so the divider output is never used for B=0.

Parameters:
- LATENCY, 2, cycles from operand capture to result capture; legal range 1..15.
- CNT_W, 4, width of the settle counter; must satisfy 2^CNT_W > LATENCY.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair and opcode valid.
- in_ready  out  1  stage can accept operands this cycle.
- in_a  in  16  operand A (multiplicand / dividend).
- in_b  in  16  operand B (multiplier / divisor).
- in_op  in  1  0 = multiply, 1 = divide.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  32  multiply: full 32-bit product; divide: {16'h0000, quotient}.
- out_op  out  1  opcode of the presented result.
- out_dz  out  1  divide-by-zero flag for the presented result.

Behaviour:
- Reset values: out_valid=0, out_result=0, out_op=0, out_dz=0, state=IDLE, counter=0, operand registers=0. in_ready reads 1 the cycle after reset. Reset takes priority over every other event and aborts any in-flight operation with no output.
- Handshake: a transfer occurs on an edge where valid&ready=1. Producers must hold data stable while valid=1 and ready=0.
- in_ready = (state==IDLE) | (state==DONE & out_ready); it is combinational from state and out_ready.
- States:
  - IDLE: on in_valid, capture in_a/in_b/in_op into operand registers, load counter with LATENCY-1, go to BUSY.
  - BUSY: decrement the counter each cycle. When counter==0, capture the result into the output registers, set out_valid=1, go to DONE.
  - DONE: hold all outputs stable while out_ready=0. If out_ready=1 and in_valid=0, clear out_valid and go to IDLE. If out_ready=1 and in_valid=1, complete both transfers on the same edge: clear out_valid, capture new operands, reload the counter, go to BUSY.
- Latency: operands accepted at edge k produce out_valid=1 at edge k+LATENCY. Peak throughput is one operation per LATENCY+1 cycles with out_ready held high.
- Operand registers stay constant from capture until the next accept, so the unit outputs are stable across the whole multicycle window.
- Result selection at capture:
  - op=0: out_result = 32-bit product, unsigned.
  - op=1, B!=0: out_result = {16'h0, A/B}, unsigned truncating.
  - op=1, B==0: out_result = 32'h0000FFFF, out_dz=1. This case still takes LATENCY cycles.
  - out_dz=0 for every other case.
- in_valid while in BUSY is ignored (in_ready=0); the producer must hold its data.
- out_ready while not in DONE has no effect.

Optional Feature:
- Macro: MULDIV_STATS_EN.
- When defined, add two outputs:
  - stat_ops (16 bits): count of results transferred downstream (out_valid&out_ready).
  - stat_dz (8 bits): count of those transfers with out_dz=1.
- Both counters reset to 0 on rst and wrap modulo 2^width without saturating.
- When not defined, neither port nor counter exists, and the core behaviour is identical.

Test Plan (all cases with LATENCY=2):
1. Basic multiply: after reset, op=0, A=300, B=200, in_valid pulsed at edge k -> out_valid rises at edge k+2, out_result=32'h0000EA60, out_dz=0, out_op=0.
2. Full-width multiply: A=16'hFFFF, B=16'hFFFF, op=0 -> out_result=32'hFFFE0001.
3. Divide and divide-by-zero:
   - A=1000, B=7, op=1 -> out_result=32'h0000008E, out_dz=0.
   - Then A=5, B=0, op=1 -> out_result=32'h0000FFFF, out_dz=1, still 2 cycles after accept.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_result and out_valid stable and in_ready=0 throughout. Then out_ready=1 with in_valid=1 carrying the next operands -> both transfers on the same edge and the next result appears 2 edges later.
5. Reset mid-operation: assert rst during BUSY -> next edge gives out_valid=0, out_result=0, in_ready=1, and no result is ever emitted for the aborted operation.
6. With MULDIV_STATS_EN: run 3 operations, one of them divide-by-zero, each consumed -> stat_ops=3, stat_dz=1. rst -> both counters read 0.

Source files
------------

// File: rtl/muldiv_issue_stage_if.sv
// Handshake bundle between the muldiv issue stage and its producer/consumer.
// Carries the operand request channel and the result channel.
// master = producer/consumer side, slave = the issue stage.
interface muldiv_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_op;
    logic        out_dz;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_dz
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_op, out_dz
    );
endinterface

// File: rtl/muldiv_issue_stage.sv
// Purpose: operand/result stage around a 16x16 unsigned multiplier and divider (div-by-zero caught here).
// Latency: LATENCY cycles from operand accept to out_valid; peak one op per LATENCY+1 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or when DONE drains this cycle.
// Optional MULDIV_STATS_EN adds stat_ops / stat_dz transfer counters.
module muldiv_issue_stage #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    muldiv_issue_stage_if.slave io
`ifdef MULDIV_STATS_EN
    ,
    output logic [15:0]         stat_ops,
    output logic [7:0]          stat_dz
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      a_q, a_d;
    logic [15:0]      b_q, b_d;
    logic             op_q, op_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic             out_op_q, out_op_d;
    logic             out_dz_q, out_dz_d;

    // Arithmetic units see only the operand registers, so their long ripple
    // paths settle across the whole multicycle window.
    logic [31:0] prod;
    logic [15:0] div_safe;
    logic [15:0] quot;
    assign prod     = {16'h0000, a_q} * {16'h0000, b_q};
    // B=0 is replaced by 1 so the divider never sees a zero divisor; its
    // output is discarded in that case anyway.
    assign div_safe = (b_q == 16'h0000) ? 16'h0001 : b_q;
    assign quot     = a_q / div_safe;

    logic accept;
    assign io.in_ready = (state_q == IDLE) | ((state_q == DONE) & io.out_ready);
    assign accept      = io.in_valid & io.in_ready;

    // Next-state: settle countdown, result capture, drain, and operand load.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_op_d     = out_op_q;
        out_dz_d     = out_dz_q;

        case (state_q)
            IDLE: ;
            BUSY: begin
                if (cnt_q == '0) begin
                    out_valid_d = 1'b1;
                    out_op_d    = op_q;
                    if (!op_q) begin
                        out_result_d = prod;
                        out_dz_d     = 1'b0;
                    end else if (b_q == 16'h0000) begin
                        out_result_d = 32'h0000_FFFF;
                        out_dz_d     = 1'b1;
                    end else begin
                        out_result_d = {16'h0000, quot};
                        out_dz_d     = 1'b0;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (io.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept only happens in IDLE or a draining DONE; it overrides the
        // return to IDLE so back-to-back ops complete both transfers at once.
        if (accept) begin
            a_d     = io.in_a;
            b_d     = io.in_b;
            op_d    = io.in_op;
            cnt_d   = CNT_W'(LATENCY - 1);
            state_d = BUSY;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_op_q     <= 1'b0;
            out_dz_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_op_q     <= out_op_d;
            out_dz_q     <= out_dz_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_result = out_result_q;
    assign io.out_op     = out_op_q;
    assign io.out_dz     = out_dz_q;

`ifdef MULDIV_STATS_EN
    logic [15:0] stat_ops_q, stat_ops_d;
    logic [7:0]  stat_dz_q, stat_dz_d;

    // Count downstream transfers; counters wrap freely.
    always_comb begin
        stat_ops_d = stat_ops_q;
        stat_dz_d  = stat_dz_q;
        if (out_valid_q & io.out_ready) begin
            stat_ops_d = stat_ops_q + 16'd1;
            if (out_dz_q) begin
                stat_dz_d = stat_dz_q + 8'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops_q <= '0;
            stat_dz_q  <= '0;
        end else begin
            stat_ops_q <= stat_ops_d;
            stat_dz_q  <= stat_dz_d;
        end
    end

    assign stat_ops = stat_ops_q;
    assign stat_dz  = stat_dz_q;
`endif

endmodule

// File: tb/tb_muldiv_issue_stage.sv
`timescale 1ns/1ps
module tb_muldiv_issue_stage;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_issue_stage_if bus();

`ifdef MULDIV_STATS_EN
    logic [15:0] stat_ops;
    logic [7:0]  stat_dz;
`endif

    muldiv_issue_stage #(.LATENCY(LAT), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .io(bus)
`ifdef MULDIV_STATS_EN
        ,
        .stat_ops(stat_ops),
        .stat_dz(stat_dz)
`endif
    );

    typedef struct {
        logic [31:0] res;
        logic        op;
        logic        dz;
        int          acc_cyc;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   tb_ops = 0;
    int   tb_dz  = 0;
    logic rand_rdy_en = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference behaviour straight from the arithmetic rules.
    function automatic exp_t model(logic [15:0] a, logic [15:0] b, logic op);
        exp_t        e;
        longint      p;
        int unsigned q;
        e.op = op;
        e.dz = 1'b0;
        e.acc_cyc = 0;
        if (!op) begin
            p = longint'(a) * longint'(b);
            e.res = p[31:0];
        end else if (b == 16'd0) begin
            e.res = 32'h0000_FFFF;
            e.dz  = 1'b1;
        end else begin
            q = int'(a) / int'(b);
            e.res = q;
        end
        return e;
    endfunction

    // Scoreboard producer: record the expected result of every accepted request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.in_valid && bus.in_ready) begin
            e = model(bus.in_a, bus.in_b, bus.in_op);
            e.acc_cyc = cyc;
            sbq.push_back(e);
        end
    end

    // Monitor: compare presented results, latency, and stall stability.
    logic        first_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_res;
    logic        prev_op, prev_dz;
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            first_seen = 1'b0;
            prev_stall = 1'b0;
            tb_ops = 0;
            tb_dz  = 0;
        end else begin
            if (prev_stall && !bus.out_valid) begin
                checks++;
                errors++;
                $display("FAIL valid_dropped: out_valid fell while out_ready was low");
            end
            if (bus.out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got result %h with nothing pending", bus.out_result);
                end else begin
                    if (!first_seen) begin
                        chk("latency", cyc, sbq[0].acc_cyc + 1 + LAT);
                        first_seen = 1'b1;
                    end
                    if (prev_stall) begin
                        chk("stall_result_stable", bus.out_result, prev_res);
                        chk("stall_op_stable", bus.out_op, prev_op);
                        chk("stall_dz_stable", bus.out_dz, prev_dz);
                    end
                    if (bus.out_ready) begin
                        chk("sb_result", bus.out_result, sbq[0].res);
                        chk("sb_op", bus.out_op, sbq[0].op);
                        chk("sb_dz", bus.out_dz, sbq[0].dz);
                        tb_ops++;
                        if (sbq[0].dz) tb_dz++;
                        void'(sbq.pop_front());
                        first_seen = 1'b0;
                    end else begin
                        chk("stall_in_ready", bus.in_ready, 0);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.out_result;
            prev_op    = bus.out_op;
            prev_dz    = bus.out_dz;
        end
    end

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_rdy_en) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Present a request and hold it until accepted; returns 1ns after the accept edge.
    task automatic send(logic [15:0] a, logic [15:0] b, logic op);
        int t = 0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_op = op;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            t++;
            if (t > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles", t);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic directed(string nm, logic [15:0] a, logic [15:0] b, logic op,
                            logic [31:0] er, logic edz);
        send(a, b, op);
        repeat (LAT) @(negedge clk);
        chk({nm, "_not_early"}, bus.out_valid, 0);
        @(negedge clk);
        chk({nm, "_valid"}, bus.out_valid, 1);
        chk({nm, "_result"}, bus.out_result, er);
        chk({nm, "_op"}, bus.out_op, op);
        chk({nm, "_dz"}, bus.out_dz, edz);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rop;
        int          t;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_op = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_result", bus.out_result, 0);
        chk("rst_out_op", bus.out_op, 0);
        chk("rst_out_dz", bus.out_dz, 0);
        chk("rst_in_ready", bus.in_ready, 1);
`ifdef MULDIV_STATS_EN
        chk("rst_stat_ops", stat_ops, 0);
        chk("rst_stat_dz", stat_dz, 0);
`endif
        @(posedge clk);
        #1 bus.out_ready = 1'b1;

        directed("mul_basic", 16'd300, 16'd200, 1'b0, 32'h0000_EA60, 1'b0);
        directed("mul_full", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, 1'b0);
        directed("div", 16'd1000, 16'd7, 1'b1, 32'h0000_008E, 1'b0);
        directed("div_zero", 16'd5, 16'd0, 1'b1, 32'h0000_FFFF, 1'b1);

        // Backpressure: hold result for 5 cycles, then drain and accept together.
        bus.out_ready = 1'b0;
        send(16'd1234, 16'd56, 1'b0);
        repeat (LAT + 1) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_result", bus.out_result, 32'h0001_0DF0);
            chk("bp_in_ready", bus.in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        directed("bp_next", 16'd40000, 16'd3, 1'b1, 32'h0000_3415, 1'b0);

        // Reset while BUSY aborts the operation silently.
        send(16'd77, 16'd88, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_out_result", bus.out_result, 0);
        chk("abort_in_ready", bus.in_ready, 1);
`ifdef MULDIV_STATS_EN
        chk("abort_stat_ops", stat_ops, 0);
        chk("abort_stat_dz", stat_dz, 0);
`endif
        repeat (6) @(negedge clk);
        chk("abort_no_output", bus.out_valid, 0);
        @(posedge clk);
        #1;

        directed("st_mul", 16'd7, 16'd9, 1'b0, 32'd63, 1'b0);
        directed("st_div", 16'd100, 16'd10, 1'b1, 32'd10, 1'b0);
        directed("st_dz", 16'd9, 16'd0, 1'b1, 32'h0000_FFFF, 1'b1);
`ifdef MULDIV_STATS_EN
        @(negedge clk);
        chk("stat_ops_3", stat_ops, 3);
        chk("stat_dz_1", stat_dz, 1);
        @(posedge clk);
        #1;
`endif

        // Random traffic with random consumer backpressure.
        rand_rdy_en = 1'b1;
        for (int n = 0; n < 200; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'd0;
                1: rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            rop = 1'($urandom_range(0, 1));
            send(ra, rb, rop);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy_en = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        t = 0;
        while (sbq.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", sbq.size(), 0);
`ifdef MULDIV_STATS_EN
        @(negedge clk);
        chk("final_stat_ops", stat_ops, 16'(tb_ops));
        chk("final_stat_dz", stat_dz, 8'(tb_dz));
`endif
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
